// File: rtl/subpel_tap_window_feeder.sv
// ---------------------------------------------------------------------------
// subpel_tap_window_feeder
//
// Purpose:
//   Front end of the sub-pixel FIR bank. It takes a square reference block of
//   WIN x WIN integer pixels as a raster stream and buffers one row at a time.
//   From each buffered row it then presents NUM_PIXEL sliding 8-tap windows,
//   one per handshake, with row/column tags. A one-cycle completion pulse
//   follows the last window of the block.
//
// Ports:
//   clock        in   rising-edge clock
//   reset        in   asynchronous, active-high reset
//   start        in   begin a new block (only looked at while idle)
//   busy         out  block in progress (LOAD or EMIT)
//   pix_in       in   unsigned pixel, raster order
//   pix_valid    in   pix_in valid
//   pix_ready    out  feeder accepts a pixel (LOAD only)
//   taps_out     out  8 taps, lane k = row_buf[col_idx+k]
//   taps_valid   out  taps_out valid (EMIT only)
//   taps_ready   in   downstream accepts the window
//   row_idx      out  current row, 0..WIN-1
//   col_idx      out  current window start column, 0..NUM_PIXEL-1
//   last_window  out  current window is the last one of the block
//   block_done   out  one-cycle pulse after the last window transfers
// ---------------------------------------------------------------------------
module subpel_tap_window_feeder #(
    parameter int NUM_PIXEL = 8,
    parameter int PIX_W     = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    output logic               busy,
    input  logic [PIX_W-1:0]   pix_in,
    input  logic               pix_valid,
    output logic               pix_ready,
    output logic [8*PIX_W-1:0] taps_out,
    output logic               taps_valid,
    input  logic               taps_ready,
    output logic [3:0]         row_idx,
    output logic [2:0]         col_idx,
    output logic               last_window,
    output logic               block_done
);

    localparam int WIN   = NUM_PIXEL + 7;
    localparam int ROW_W = 4;
    localparam int COL_W = 3;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_EMIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [PIX_W-1:0]   r_row_buf [0:WIN-1];
    logic [CNT_W-1:0]   r_load_cnt;
    logic [ROW_W-1:0]   r_row_idx;
    logic [COL_W-1:0]   r_col_idx;

    logic               w_pix_fire;
    logic               w_taps_fire;
    logic               w_row_full;
    logic               w_col_last;
    logic               w_row_last;

    assign w_pix_fire  = pix_valid & pix_ready;
    assign w_taps_fire = taps_valid & taps_ready;
    assign w_row_full  = (r_load_cnt == CNT_W'(WIN - 1));
    assign w_col_last  = (r_col_idx == COL_W'(NUM_PIXEL - 1));
    assign w_row_last  = (r_row_idx == ROW_W'(WIN - 1));

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next state and state-decoded outputs
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        pix_ready    = 1'b0;
        taps_valid   = 1'b0;
        block_done   = 1'b0;
        last_window  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                busy      = 1'b1;
                pix_ready = 1'b1;
                if (w_pix_fire && w_row_full) begin
                    w_state_next = S_EMIT;
                end
            end
            S_EMIT: begin
                busy        = 1'b1;
                taps_valid  = 1'b1;
                last_window = w_row_last & w_col_last;
                if (w_taps_fire && w_col_last) begin
                    w_state_next = w_row_last ? S_DONE : S_LOAD;
                end
            end
            S_DONE: begin
                // start is deliberately not examined here; a new block can
                // only begin from the idle cycle that follows.
                block_done   = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Load counter and row/column position
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_load_cnt <= '0;
            r_row_idx  <= '0;
            r_col_idx  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_load_cnt <= '0;
                        r_row_idx  <= '0;
                        r_col_idx  <= '0;
                    end
                end
                S_LOAD: begin
                    if (w_pix_fire) begin
                        if (w_row_full) begin
                            r_load_cnt <= '0;
                            r_col_idx  <= '0;
                        end else begin
                            r_load_cnt <= r_load_cnt + 1'b1;
                        end
                    end
                end
                S_EMIT: begin
                    if (w_taps_fire) begin
                        if (!w_col_last) begin
                            r_col_idx <= r_col_idx + 1'b1;
                        end else if (!w_row_last) begin
                            r_row_idx <= r_row_idx + 1'b1;
                            r_col_idx <= '0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Row buffer. Eight windows taps are read in parallel every cycle, so
    // this is a register file rather than a RAM; it is cleared on reset so
    // a partially loaded row never leaks into the next block.
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < WIN; i++) begin
                r_row_buf[i] <= '0;
            end
        end else if (w_pix_fire) begin
            r_row_buf[r_load_cnt] <= pix_in;
        end
    end

    // -----------------------------------------------------------------------
    // Tap window mux: lane gi reads row_buf[col_idx+gi]. The largest index is
    // (NUM_PIXEL-1)+7 = WIN-1, so the window never runs off the row.
    // -----------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_tap
            logic [CNT_W-1:0] w_tap_idx;
            assign w_tap_idx = CNT_W'(r_col_idx) + CNT_W'(gi);
            assign taps_out[PIX_W*gi +: PIX_W] = r_row_buf[w_tap_idx];
        end
    endgenerate

    assign row_idx = r_row_idx;
    assign col_idx = r_col_idx;

endmodule

// File: tb/tb_subpel_tap_window_feeder.sv
// ---------------------------------------------------------------------------
// tb_subpel_tap_window_feeder
//
// Directed bench for subpel_tap_window_feeder (NUM_PIXEL=8, PIX_W=8).
// Pixels follow value = (row*16 + col + base) mod 256, so every window has a
// hand-checkable expected value. Outputs are sampled and inputs driven on
// the falling edge; the DUT registers on the rising edge.
// ---------------------------------------------------------------------------
module tb_subpel_tap_window_feeder;

    localparam int NP   = 8;
    localparam int PW   = 8;
    localparam int WIN  = NP + 7;
    localparam int NWIN = WIN * NP;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [PW-1:0] pix_in = '0;
    logic          pix_valid = 1'b0;
    logic          taps_ready = 1'b0;
    logic          busy;
    logic          pix_ready;
    logic [8*PW-1:0] taps_out;
    logic          taps_valid;
    logic [3:0]    row_idx;
    logic [2:0]    col_idx;
    logic          last_window;
    logic          block_done;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    subpel_tap_window_feeder #(
        .NUM_PIXEL (NP),
        .PIX_W     (PW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .busy        (busy),
        .pix_in      (pix_in),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .taps_out    (taps_out),
        .taps_valid  (taps_valid),
        .taps_ready  (taps_ready),
        .row_idx     (row_idx),
        .col_idx     (col_idx),
        .last_window (last_window),
        .block_done  (block_done)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [PW-1:0] pix_val(input int r, input int c, input int base);
        return PW'((r * 16 + c + base) & 255);
    endfunction

    function automatic logic [63:0] win_val(input int r, input int c, input int base);
        logic [63:0] w;
        w = '0;
        for (int k = 0; k < 8; k++) begin
            w[8*k +: 8] = pix_val(r, c + k, base);
        end
        return w;
    endfunction

    // Runs one block starting from an idle falling edge. Options:
    //   gaps      - pix_valid toggles every cycle during row 0
    //   stall     - taps_ready held low 3 cycles at row 0, col 2
    //   ffill     - pix_valid=1 with 0xFF whenever the feeder is not loading
    //   mid_start - start pulsed during EMIT (must be ignored)
    //   abort_p   - return early once this many pixels are accepted (-1: never)
    task automatic run_block(input int base, input bit gaps, input bit stall,
                             input bit ffill, input bit mid_start, input int abort_p);
        int p;
        int w;
        int cyc;
        int er;
        int ec;
        int stall_left;
        bit stall_done;
        bit vtog;
        bit exp_tv;
        p = 0; w = 0; cyc = 0; stall_left = 0; stall_done = 0; vtog = 0;

        start      = 1'b1;
        pix_valid  = 1'b0;
        taps_ready = 1'b0;
        @(negedge clock);
        start = 1'b0;
        check_eq("busy_after_start", 64'(busy), 64'd1);

        while (w < NWIN) begin
            cyc++;
            if (cyc > 3000) begin
                check_eq("timeout_windows", 64'(w), 64'(NWIN));
                pix_valid = 1'b0;
                return;
            end
            er     = w / NP;
            ec     = w % NP;
            exp_tv = (p == WIN * (er + 1));
            check_eq("taps_valid", 64'(taps_valid), 64'(exp_tv));
            check_eq("pix_ready", 64'(pix_ready), 64'(!exp_tv));
            check_eq("busy", 64'(busy), 64'd1);
            check_eq("block_done_early", 64'(block_done), 64'd0);
            if (abort_p >= 0 && p == abort_p) begin
                pix_valid = 1'b0;
                return;
            end
            start = mid_start && exp_tv && (w == 20);
            if (!exp_tv) begin
                vtog       = ~vtog;
                pix_valid  = (gaps && er == 0) ? vtog : 1'b1;
                pix_in     = pix_val(er, p - WIN * er, base);
                taps_ready = 1'b1;
                if (pix_valid) p++;
            end else begin
                pix_valid = ffill;
                pix_in    = ffill ? 8'hFF : 8'h00;
                check_eq("taps_out", taps_out, win_val(er, ec, base));
                check_eq("row_idx", 64'(row_idx), 64'(er));
                check_eq("col_idx", 64'(col_idx), 64'(ec));
                check_eq("last_window", 64'(last_window), 64'(w == NWIN - 1));
                if (base == 0 && er == 0 && ec == 0)
                    check_eq("first_win_const", taps_out, 64'h0706050403020100);
                if (base == 0 && er == 1 && ec == 3)
                    check_eq("r1c3_const", taps_out, 64'h1A19181716151413);
                if (base == 0 && er == 14 && ec == 7)
                    check_eq("last_win_const", taps_out, 64'hEEEDECEBEAE9E8E7);
                if (stall && er == 0 && ec == 2 && !stall_done) begin
                    check_eq("stall_taps_const", taps_out, 64'h0908070605040302);
                    if (stall_left == 0) stall_left = 3;
                    stall_left--;
                    if (stall_left == 0) stall_done = 1'b1;
                    taps_ready = 1'b0;
                end else begin
                    taps_ready = 1'b1;
                    $display("win base=%0h r=%0d c=%0d taps=%h last=%0d",
                             base, er, ec, taps_out, last_window);
                    w++;
                end
            end
            @(negedge clock);
        end

        start      = 1'b1;   // arrives in DONE: must be ignored
        pix_valid  = 1'b0;
        taps_ready = 1'b0;
        check_eq("block_done", 64'(block_done), 64'd1);
        check_eq("busy_in_done", 64'(busy), 64'd0);
        check_eq("taps_valid_done", 64'(taps_valid), 64'd0);
        @(negedge clock);
        start = 1'b0;
        check_eq("block_done_one_cycle", 64'(block_done), 64'd0);
        check_eq("busy_idle", 64'(busy), 64'd0);
        check_eq("pix_ready_idle", 64'(pix_ready), 64'd0);
        $display("block base=%0h done after %0d loop cycles", base, cyc);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_busy"},       64'(busy),        64'd0);
        check_eq({tag, "_pix_ready"},  64'(pix_ready),   64'd0);
        check_eq({tag, "_taps_valid"}, 64'(taps_valid),  64'd0);
        check_eq({tag, "_taps_out"},   taps_out,         64'd0);
        check_eq({tag, "_row_idx"},    64'(row_idx),     64'd0);
        check_eq({tag, "_col_idx"},    64'(col_idx),     64'd0);
        check_eq({tag, "_last"},       64'(last_window), 64'd0);
        check_eq({tag, "_done"},       64'(block_done),  64'd0);
    endtask

    initial begin
        #1 reset = 1'b1;
        #1 check_all_zero("reset");
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check_all_zero("idle");

        // Start while idle with pix_valid high: nothing is accepted.
        pix_valid = 1'b1;
        pix_in    = 8'hAA;
        @(negedge clock);
        check_eq("idle_pix_ready", 64'(pix_ready), 64'd0);
        pix_valid = 1'b0;

        // Basic block, then a back-to-back block with backpressure, 0xFF
        // driven outside LOAD and an ignored mid-block start.
        run_block(0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        run_block(0, 1'b0, 1'b1, 1'b1, 1'b1, -1);
        // Input gaps on row 0.
        run_block(0, 1'b1, 1'b0, 1'b0, 1'b0, -1);

        // Reset during LOAD of row 4 after 6 pixels.
        run_block(8'h30, 1'b0, 1'b0, 1'b0, 1'b0, WIN * 4 + 6);
        check_eq("pre_reset_row", 64'(row_idx), 64'd4);
        #2 reset = 1'b1;
        #1 check_all_zero("async_reset");
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check_all_zero("post_reset");
        run_block(8'h80, 1'b0, 1'b0, 1'b0, 1'b0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
